// File: rtl/regfile_reader.sv
// Purpose: 8 x DATA_W register file (reg 0 hard-wired to zero) with two registered read
//          ports and a serial dump engine that streams all 8 registers over a valid/ready beat.
// Latency: read data 1 cycle after rd_req; dump beat 0 appears the cycle after dump_start.
// Backpressure: rd_req has none; a dump beat holds idx/data while dump_ready is low.
//
// Ports:
//   clk, rst               - single clock, synchronous active-high reset
//   we_onehot, wdata       - one-hot write enables (bit i -> reg i) and write data
//   rd_req, ra_sel, rb_sel - read request and selects for both read ports
//   ra_data, rb_data       - registered read data, held while rd_valid is low
//   rd_valid               - one-cycle pulse per read request
//   dump_start             - start a dump of regs 0..7 (only honoured when idle)
//   dump_ready             - consumer accepts the current dump beat
//   dump_valid, dump_idx,
//   dump_data              - current dump beat
//   dump_busy, dump_done   - dump in progress / one-cycle completion pulse
module regfile_reader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        we_onehot,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic [2:0]        ra_sel,
    input  logic [2:0]        rb_sel,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              rd_valid,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [2:0]        dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic [DATA_W-1:0] ra_data_q, ra_data_d;
    logic [DATA_W-1:0] rb_data_q, rb_data_d;
    logic              rd_valid_q, rd_valid_d;

    state_e            state_q, state_d;
    logic [2:0]        dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic [2:0]        idx_next;

    // regs_d is the post-write view of the file. Every capture (read ports and dump
    // beats) samples regs_d rather than regs_q, which gives same-edge write bypass
    // for free and keeps register 0 at zero.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 8; i++) begin
            if (we_onehot[i]) begin
                regs_d[i] = wdata;
            end
        end
        regs_d[0] = '0;
    end

    // Read ports: capture on request, otherwise hold the last value.
    always_comb begin
        ra_data_d  = ra_data_q;
        rb_data_d  = rb_data_q;
        rd_valid_d = rd_req;
        if (rd_req) begin
            ra_data_d = regs_d[ra_sel];
            rb_data_d = regs_d[rb_sel];
        end
    end

    assign idx_next = dump_idx_q + 3'd1;

    // Dump FSM: next state, beat index and beat data.
    always_comb begin
        state_d     = state_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d     = ST_SEND;
                    dump_idx_d  = 3'd0;
                    dump_data_d = regs_d[0];
                end
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (dump_idx_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        // Next beat is captured on the same edge that accepts this one.
                        dump_idx_d  = idx_next;
                        dump_data_d = regs_d[idx_next];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Dump status outputs decode directly from state.
    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            ST_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            ST_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
            end
            default: begin
                dump_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            ra_data_q   <= '0;
            rb_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            state_q     <= ST_IDLE;
            dump_idx_q  <= 3'd0;
            dump_data_q <= '0;
        end else begin
            regs_q      <= regs_d;
            ra_data_q   <= ra_data_d;
            rb_data_q   <= rb_data_d;
            rd_valid_q  <= rd_valid_d;
            state_q     <= state_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign ra_data   = ra_data_q;
    assign rb_data   = rb_data_q;
    assign rd_valid  = rd_valid_q;
    assign dump_idx  = dump_idx_q;
    assign dump_data = dump_data_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Purpose: directed self-checking bench for regfile_reader.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: dump_ready driven directly by the stimulus.
module tb_regfile_reader;

    logic        clk;
    logic        rst;
    logic [7:0]  we_onehot;
    logic [31:0] wdata;
    logic        rd_req;
    logic [2:0]  ra_sel;
    logic [2:0]  rb_sel;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        rd_valid;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [2:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_reader #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .we_onehot  (we_onehot),
        .wdata      (wdata),
        .rd_req     (rd_req),
        .ra_sel     (ra_sel),
        .rb_sel     (rb_sel),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .rd_valid   (rd_valid),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at that edge and
    // outputs are observed 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_onehot  = 8'h00;
        wdata      = 32'h0;
        rd_req     = 1'b0;
        ra_sel     = 3'd0;
        rb_sel     = 3'd0;
        dump_start = 1'b0;
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, ".valid"}, 32'(dump_valid), 32'd0);
        check({tag, ".busy"},  32'(dump_busy),  32'd0);
        check({tag, ".done"},  32'(dump_done),  32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        dump_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst.ra_data",   ra_data,          32'h0);
        check("rst.rb_data",   rb_data,          32'h0);
        check("rst.rd_valid",  32'(rd_valid),    32'd0);
        check("rst.dump_idx",  32'(dump_idx),    32'd0);
        check("rst.dump_data", dump_data,        32'h0);
        check_dump_idle("rst");

        // Write reg 3, read it next cycle with reg 0 on port b
        we_onehot = 8'b0000_1000; wdata = 32'h1234;
        tick();
        idle_inputs();
        rd_req = 1'b1; ra_sel = 3'd3; rb_sel = 3'd0;
        tick();
        idle_inputs();
        check("rd1.ra_data",  ra_data,       32'h1234);
        check("rd1.rb_data",  rb_data,       32'h0);
        check("rd1.rd_valid", 32'(rd_valid), 32'd1);
        tick();
        check("rd1.valid_drop", 32'(rd_valid), 32'd0);
        check("rd1.ra_hold",    ra_data,       32'h1234);

        // Writes to reg 0 are ignored
        we_onehot = 8'b0000_0001; wdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        rd_req = 1'b1; ra_sel = 3'd0; rb_sel = 3'd3;
        tick();
        idle_inputs();
        check("r0.ra_data", ra_data, 32'h0);
        check("r0.rb_data", rb_data, 32'h1234);

        // Same-cycle write bypass to reg 5, then a back-to-back read
        we_onehot = 8'b0010_0000; wdata = 32'hABCD;
        rd_req = 1'b1; ra_sel = 3'd5; rb_sel = 3'd0;
        tick();
        we_onehot = 8'h00; wdata = 32'h0;
        rd_req = 1'b1; ra_sel = 3'd0; rb_sel = 3'd5;
        check("byp.ra_data",  ra_data,       32'hABCD);
        check("byp.rd_valid", 32'(rd_valid), 32'd1);
        tick();
        idle_inputs();
        check("b2b.rb_data",  rb_data,       32'hABCD);
        check("b2b.ra_data",  ra_data,       32'h0);
        check("b2b.rd_valid", 32'(rd_valid), 32'd1);

        // Load regs 1..7 with i*0x11 and dump with dump_ready tied high
        for (int i = 1; i < 8; i++) begin
            we_onehot = 8'(1 << i);
            wdata     = 32'(i * 32'h11);
            tick();
        end
        idle_inputs();
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check($sformatf("d1.valid%0d", b), 32'(dump_valid), 32'd1);
            check($sformatf("d1.busy%0d", b),  32'(dump_busy),  32'd1);
            check($sformatf("d1.idx%0d", b),   32'(dump_idx),   32'(b));
            check($sformatf("d1.data%0d", b),  dump_data,       32'(b * 32'h11));
            tick();
        end
        check("d1.done",      32'(dump_done),  32'd1);
        check("d1.done_vld",  32'(dump_valid), 32'd0);
        check("d1.done_busy", 32'(dump_busy),  32'd1);
        tick();
        check_dump_idle("d1.end");

        // Stall at idx 2 for 5 cycles while reg 2 and reg 3 are rewritten,
        // a second dump_start arrives and a normal read is serviced.
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("d2.idx0", 32'(dump_idx), 32'd0);
        dump_ready = 1'b1;
        tick();
        tick();
        dump_ready = 1'b0;
        check("d2.idx2",  32'(dump_idx), 32'd2);
        check("d2.data2", dump_data,     32'h22);
        for (int h = 0; h < 5; h++) begin
            idle_inputs();
            if (h == 0) begin we_onehot = 8'b0000_0100; wdata = 32'h99; end
            if (h == 1) begin we_onehot = 8'b0000_1000; wdata = 32'hA5; end
            if (h == 2) dump_start = 1'b1;
            if (h == 3) begin rd_req = 1'b1; ra_sel = 3'd2; rb_sel = 3'd3; end
            tick();
            check($sformatf("stall.valid%0d", h), 32'(dump_valid), 32'd1);
            check($sformatf("stall.idx%0d", h),   32'(dump_idx),   32'd2);
            check($sformatf("stall.data%0d", h),  dump_data,       32'h22);
        end
        // Read issued at h=3 lands here-one cycle later, already checked dump above
        idle_inputs();
        check("mid.ra_data", ra_data, 32'h99);
        check("mid.rb_data", rb_data, 32'hA5);
        dump_ready = 1'b1;
        tick();
        check("d2.idx3",  32'(dump_idx), 32'd3);
        check("d2.data3", dump_data,     32'hA5);
        for (int b = 4; b < 8; b++) begin
            tick();
            check($sformatf("d2.idx%0d", b),  32'(dump_idx), 32'(b));
            check($sformatf("d2.data%0d", b), dump_data,     32'(b * 32'h11));
        end
        tick();
        check("d2.done", 32'(dump_done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_dump_idle($sformatf("d2.after%0d", k));
        end

        // Reset at idx 4 aborts the dump; writes/read/start in that cycle lose to reset
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 1; b < 5; b++) tick();
        check("d3.idx4", 32'(dump_idx), 32'd4);
        rst = 1'b1;
        we_onehot = 8'hFE; wdata = 32'hDEAD;
        rd_req = 1'b1; ra_sel = 3'd4; rb_sel = 3'd7;
        dump_start = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check("ar.ra_data",   ra_data,       32'h0);
        check("ar.rb_data",   rb_data,       32'h0);
        check("ar.rd_valid",  32'(rd_valid), 32'd0);
        check("ar.dump_idx",  32'(dump_idx), 32'd0);
        check("ar.dump_data", dump_data,     32'h0);
        check_dump_idle("ar");
        tick();
        check_dump_idle("ar.next");
        for (int r = 0; r < 8; r++) begin
            rd_req = 1'b1; ra_sel = 3'(r); rb_sel = 3'(7 - r);
            tick();
            check($sformatf("ar.rega%0d", r), ra_data, 32'h0);
            check($sformatf("ar.regb%0d", r), rb_data, 32'h0);
            check($sformatf("ar.rvld%0d", r), 32'(rd_valid), 32'd1);
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter: DATA_W, 32, register and data-port width.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: we_onehot  input  8  one-hot write enables from write-enable decoder, bit i writes register i.
REQ-005 SHALL have port: wdata  input  DATA_W  write data.
REQ-006 SHALL have port: rd_req  input  1  read request for both read ports.
REQ-007 SHALL have port: ra_sel / rb_sel  input  3 each  read register selects.
REQ-008 SHALL have port: ra_data / rb_data  output  DATA_W each  registered read data.
REQ-009 SHALL have port: rd_valid  output  1  read data valid, one-cycle pulse per request.
REQ-010 SHALL have port: dump_start  input  1  start serial dump of all 8 registers.
REQ-011 SHALL have port: dump_ready  input  1  consumer accepts current dump beat.
REQ-012 SHALL have port: dump_valid  output  1  dump beat present.
REQ-013 SHALL have port: dump_idx  output  3  register index of current beat.
REQ-014 SHALL have port: dump_data  output  DATA_W  register contents of current beat.
REQ-015 SHALL have port: dump_busy / dump_done  output  1 each  dump in progress / one-cycle completion pulse.

Function
REQ-016 SHALL store 8 registers of DATA_W bits; register 0 SHALL read as zero and ignore writes.
REQ-017 SHALL, on a clock edge, write wdata into every register i (i != 0) whose we_onehot bit is set; multiple set bits write all flagged registers, no bits set writes nothing.
REQ-018 SHALL, for rd_req high in cycle N, present ra_data/rb_data and rd_valid=1 in cycle N+1; latency exactly 1, back-to-back requests each produce a valid cycle.
REQ-019 SHALL bypass: a write in cycle N to the register selected by ra_sel or rb_sel SHALL make cycle N+1 data equal the cycle-N wdata (except register 0, still zero).
REQ-020 SHALL hold ra_data/rb_data at last value when rd_valid is low.
REQ-021 SHALL implement dump FSM states IDLE, SEND, DONE.
REQ-022 IDLE: dump_start high -> SEND next cycle with dump_idx=0; dump_start ignored in SEND and DONE.
REQ-023 SEND: dump_valid=1, dump_busy=1; dump_data SHALL be captured on entering each beat (including write bypass at that edge) and held stable until accepted.
REQ-024 SEND: dump_valid and dump_ready high -> if dump_idx<7 increment dump_idx and capture next beat in the same edge; if dump_idx=7 -> DONE.
REQ-025 DONE: dump_done=1, dump_valid=0, dump_busy=1 for exactly one cycle, then IDLE.
REQ-026 SHALL keep dump_valid high without advancing while dump_ready is low, for any number of cycles.
REQ-027 SHALL service rd_req and writes normally during a dump; writes affect only beats captured afterwards.

Reset
REQ-028 SHALL, with rst high at a clock edge, clear all registers to 0, ra_data/rb_data to 0, rd_valid, dump_valid, dump_busy, dump_done to 0, dump_idx and dump_data to 0, FSM to IDLE.
REQ-029 SHALL give rst priority over writes, rd_req and dump_start in the same cycle; reset during SEND aborts the dump with no dump_done pulse.

Verification
REQ-030 SHALL verify: write 0x1234 via we_onehot=8'b0000_1000, next cycle rd_req ra_sel=3 rb_sel=0 -> one cycle later ra_data=0x1234, rb_data=0, rd_valid=1.
REQ-031 SHALL verify: we_onehot=8'b0000_0001 wdata=0xFFFF_FFFF then read reg 0 -> 0; same-cycle write 0xABCD to reg 5 with rd_req ra_sel=5 -> ra_data=0xABCD next cycle.
REQ-032 SHALL verify: registers 1..7 loaded with i*0x11, dump_start, dump_ready tied high -> 8 consecutive beats idx 0..7 data 0,0x11..0x77, then dump_done one cycle, then IDLE.
REQ-033 SHALL verify: dump_ready low 5 cycles at idx 2 while reg 2 rewritten to 0x99 -> dump_data stays 0x22 and idx 2 throughout; reg 3 rewritten before its beat shows new value.
REQ-034 SHALL verify: rst asserted at dump idx 4 -> next cycle all outputs 0, dump_busy 0, no dump_done, all registers read 0.
REQ-035 SHALL verify: dump_start asserted again mid-dump -> ignored, sequence still ends after idx 7 with single dump_done.
